fwd_bypass_unit: RTL
====================

Name: fwd_bypass_unit

Overview:
- Parametrised operand-forwarding unit for the MIPS pipeline; successor to the fixed 3-input, 32-bit forwarding mux.
- Holds a DEPTH-entry history of in-flight register writes.
  - Stage 0 is MEM; stage DEPTH-1 is the oldest, the one being written to the register file.
- Resolves NRD read-port operands from the youngest matching write.
- Raises a load-use stall when the youngest matching producer has no data yet.

Parameters:
- DW, 32, data width.
- AW, 5, register address width.
- DEPTH, 3, number of forwarding stages held, at least 1.
- NRD, 2, number of read ports (channels).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- adv  in  1  pipeline advance; 0 means freeze the history
- wr_en  in  1  instruction leaving EX writes a register
- wr_addr  in  AW  its destination register
- wr_rdy  in  1  data is available now (0 means a load, data comes later)
- wr_data  in  DW  EX result; ignored when wr_rdy=0
- ld_fill  in  1  load data returned
- ld_data  in  DW  load data
- rd_addr  in  NRD*AW  read-port source registers, port k at bits [k*AW +: AW]
- rf_data  in  NRD*DW  register-file read data per port
- operand  out  NRD*DW  forwarded operand per port
- fwd_sel  out  NRD*(DEPTH+1 clog2)  per port: 0 = register file, s+1 = stage s
- stall  out  1  OR over ports of the pending-match condition
- err  out  1  sticky: ld_fill seen with no pending entry

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset state:
  - All entries invalid; ready and data bits are 0.
  - err=0.
  - Outputs are therefore operand=rf_data, fwd_sel=0, stall=0.
- Entry fields: v, addr, rdy, data.
- Shift when adv=1 at posedge:
  - Stage 0 loads {wr_en && wr_addr!=0, wr_addr, wr_rdy, wr_data}.
  - Stage s loads from stage s-1.
  - The oldest entry is discarded.
- Hold when adv=0: entries keep their values. Fill and err updates still apply.
- Fill when ld_fill=1:
  - Target is the youngest valid entry with rdy=0, after the shift is applied; the shift and the fill happen in the same edge.
  - Target gets rdy=1 and data=ld_data.
  - If there is no pending entry, err is set and stays set until rst.
  - A fill never targets the entry being loaded into stage 0 in the same edge. A same-edge EX load stays pending.
- Read resolution, combinational from registered state only:
  - For port k, find the lowest stage s with v=1 and addr==rd_addr[k].
  - Register 0 is never matched; it returns rf_data.
  - Match with rdy=1: operand=data[s], fwd_sel=s+1.
  - Match with rdy=0: operand=rf_data (don't-care), fwd_sel=s+1, stall=1.
  - No match: operand=rf_data[k], fwd_sel=0.
- Priority: the youngest stage wins. An older ready entry is never used when a younger match is pending.
- Latency:
  - A write issued at edge N is forwardable from cycle N+1.
  - A load filled at edge M is forwardable from cycle M+1.
- The unit never drives adv. The pipeline controller inserts a bubble (wr_en=0) while stall=1.
- Reset mid-operation: the whole history is cleared in the same edge, including pending loads. Fill and shift are ignored while rst=1.

Decomposition:
- Shared package:
  - Entry struct {v, addr, rdy, data}.
  - REG_ZERO constant.
  - fwd_sel width function clog2(DEPTH+1).
- Natural sub-module: fwd_port_resolve.
  - One instance per read port, generated NRD times.
  - Priority match over the DEPTH entries, returning operand, fwd_sel and pending.
- The top level holds the history register, the shift, fill and err logic, and the stall OR.

Test Plan (defaults DW=32, AW=5, DEPTH=3, NRD=2):
1. Reset, then read rd_addr={r4,r3} with rf_data={0x11,0x22}.
   - Required: operand=rf_data, fwd_sel=0, stall=0.
2. adv=1, write r3=0xDEADBEEF (wr_rdy=1), then read r3 on port 0 for 3 cycles with adv=1.
   - Required: fwd_sel=1, 2, 3 in successive cycles, operand=0xDEADBEEF each time.
   - Fourth cycle: fwd_sel=0.
3. Write r5=0xA, then next cycle r5=0xB, then read r5.
   - Required: operand=0xB, fwd_sel=1 (youngest wins).
4. Load to r7 (wr_rdy=0), read r7.
   - Required: stall=1, fwd_sel=1.
   - Assert ld_fill with ld_data=0x1234 and adv=1 while the bubble is shifted in.
   - Next cycle: stall=0, fwd_sel=2, operand=0x1234.
5. wr_en=1 with wr_addr=0 and wr_data=0xFF, then read r0.
   - Required: operand=rf_data, fwd_sel=0.
   - ld_fill with nothing pending: err=1, held until rst.
6. A pending load at stage 0 with adv=0 for 2 cycles: stall stays 1 and the history is unchanged.
   - Then assert rst: next cycle all entries are invalid, stall=0, err=0.

Source files
------------

// File: rtl/fwd_bypass_unit_pkg.sv
// Shared constants and helpers for the operand-forwarding unit.
package fwd_bypass_unit_pkg;

    // Architectural zero register: never produced, never forwarded.
    localparam int REG_ZERO = 0;

    // Width of a per-port forwarding select: values 0 (register file) .. DEPTH.
    function automatic int sel_width(input int depth);
        return ($clog2(depth + 1) < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_port_resolve.sv
// Priority match of one read port against the forwarding history.
module fwd_port_resolve
    import fwd_bypass_unit_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int SW    = 2
) (
    input  logic [AW-1:0]                rd_addr,
    input  logic [DW-1:0]                rf_data,
    input  logic [DEPTH-1:0]             ent_v,
    input  logic [DEPTH-1:0][AW-1:0]     ent_addr,
    input  logic [DEPTH-1:0]             ent_rdy,
    input  logic [DEPTH-1:0][DW-1:0]     ent_data,
    output logic [DW-1:0]                operand,
    output logic [SW-1:0]                fwd_sel,
    output logic                         pending
);

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        operand = rf_data;
        fwd_sel = '0;
        pending = 1'b0;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (ent_v[s] && ent_addr[s] == rd_addr && rd_addr != AW'(REG_ZERO)) begin
                fwd_sel = SW'(s + 1);
                pending = !ent_rdy[s];
                operand = ent_rdy[s] ? ent_data[s] : rf_data;
            end
        end
    end

endmodule

// File: rtl/fwd_bypass_unit.sv
// Operand-forwarding unit: write history, load fill tracking, per-port resolve.
module fwd_bypass_unit
    import fwd_bypass_unit_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int NRD   = 2,
    localparam int SW   = sel_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                adv,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic                wr_rdy,
    input  logic [DW-1:0]       wr_data,
    input  logic                ld_fill,
    input  logic [DW-1:0]       ld_data,
    input  logic [NRD*AW-1:0]   rd_addr,
    input  logic [NRD*DW-1:0]   rf_data,
    output logic [NRD*DW-1:0]   operand,
    output logic [NRD*SW-1:0]   fwd_sel,
    output logic                stall,
    output logic                err
);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] addr;
        logic          rdy;
        logic [DW-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] hist;
    entry_t [DEPTH-1:0] shifted;
    entry_t [DEPTH-1:0] hist_nxt;
    logic               fill_hit;

    logic [DEPTH-1:0]         ent_v;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0]         ent_rdy;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic [NRD-1:0]           pend;

    // Shift (when advancing) then apply the load fill to the youngest pending
    // entry; the entry entering stage 0 this edge is never a fill target.
    always_comb begin
        shifted = hist;
        if (adv) begin
            for (int s = DEPTH - 1; s > 0; s--) shifted[s] = hist[s-1];
            shifted[0].v    = wr_en && (wr_addr != AW'(REG_ZERO));
            shifted[0].addr = wr_addr;
            shifted[0].rdy  = wr_rdy;
            shifted[0].data = wr_rdy ? wr_data : '0;
        end
        hist_nxt = shifted;
        fill_hit = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            if (!fill_hit && !(adv && s == 0) && shifted[s].v && !shifted[s].rdy) begin
                fill_hit = 1'b1;
                if (ld_fill) begin
                    hist_nxt[s].rdy  = 1'b1;
                    hist_nxt[s].data = ld_data;
                end
            end
        end
    end

    // History register; reset clears everything including pending loads.
    always_ff @(posedge clk) begin
        if (rst) hist <= '0;
        else     hist <= hist_nxt;
    end

    // Sticky error: a fill arrived with no load outstanding.
    always_ff @(posedge clk) begin
        if (rst)                     err <= 1'b0;
        else if (ld_fill && !fill_hit) err <= 1'b1;
    end

    // Unpack the history into per-field arrays for the resolvers.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            ent_v[s]    = hist[s].v;
            ent_addr[s] = hist[s].addr;
            ent_rdy[s]  = hist[s].rdy;
            ent_data[s] = hist[s].data;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        fwd_port_resolve #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SW(SW)) u_res (
            .rd_addr  (rd_addr[k*AW +: AW]),
            .rf_data  (rf_data[k*DW +: DW]),
            .ent_v    (ent_v),
            .ent_addr (ent_addr),
            .ent_rdy  (ent_rdy),
            .ent_data (ent_data),
            .operand  (operand[k*DW +: DW]),
            .fwd_sel  (fwd_sel[k*SW +: SW]),
            .pending  (pend[k])
        );
    end

    assign stall = |pend;

endmodule
